// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
//   Shared definitions for frame_accumulator.
//   - acc_state_e : FSM states (ST_ACC collects samples, ST_HOLD presents result)
//   - CNT_W       : width of the per-frame sample counter (NFRAME <= 2**16-1)
//   - ACC_W_MAX   : widest accumulator sat_add can handle (NACC must be < this)
//   - sat_add     : saturating add; returns {clamped, sum}, sum clamped at
//                   2**nacc-1 and clamped=1 whenever the clamp was applied.
// ---------------------------------------------------------------------------
package acc_pkg;

    localparam int ACC_W_MAX = 32;
    localparam int CNT_W     = 16;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_e;

    // Saturating add of a zero-extended sample onto an accumulator that is
    // nacc bits wide. Operands arrive zero-extended to ACC_W_MAX bits.
    function automatic logic [ACC_W_MAX:0] sat_add(
        input logic [ACC_W_MAX-1:0] acc,
        input logic [ACC_W_MAX-1:0] smp,
        input int unsigned          nacc
    );
        logic [ACC_W_MAX:0] sum;
        logic [ACC_W_MAX:0] lim;
        sum = {1'b0, acc} + {1'b0, smp};
        lim = ({{ACC_W_MAX{1'b0}}, 1'b1} << nacc) - {{ACC_W_MAX{1'b0}}, 1'b1};
        if (sum > lim) begin
            return {1'b1, lim[ACC_W_MAX-1:0]};
        end else begin
            return {1'b0, sum[ACC_W_MAX-1:0]};
        end
    endfunction

endpackage

// File: rtl/frame_accumulator.sv
// ---------------------------------------------------------------------------
// frame_accumulator
//   Sums NFRAME unsigned NX-bit samples per frame into a saturating NACC-bit
//   accumulator and presents the frame total plus a sticky overflow flag on a
//   valid/ready output port. While a result is held the input is stalled.
//
//   Optional feature macro: ACC_MINMAX_EN
//     When defined, o_out_min/o_out_max report the smallest/largest sample
//     of each frame, registered together with o_out_sum.
//
// Parameters
//   NX      sample width (unsigned)
//   NFRAME  samples per frame, 1 .. 2**16-1
//   NACC    accumulator/output width, NX <= NACC < 32
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clr        synchronous clear, abandons the current frame and any
//                pending result
//   i_in_data    input sample
//   i_in_valid   input sample valid
//   o_in_ready   block accepts a sample this cycle
//   o_out_sum    frame total (saturated)
//   o_out_ovf    frame total saturated
//   o_out_valid  o_out_sum/o_out_ovf valid
//   i_out_ready  downstream takes the result
//   o_out_min    (ACC_MINMAX_EN) smallest sample of the frame
//   o_out_max    (ACC_MINMAX_EN) largest sample of the frame
// ---------------------------------------------------------------------------
module frame_accumulator #(
    parameter int unsigned NX     = 8,
    parameter int unsigned NFRAME = 16,
    parameter int unsigned NACC   = 16
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic [NX-1:0]   i_in_data,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic [NACC-1:0] o_out_sum,
    output logic            o_out_ovf,
    output logic            o_out_valid,
    input  logic            i_out_ready
`ifdef ACC_MINMAX_EN
    ,
    output logic [NX-1:0]   o_out_min,
    output logic [NX-1:0]   o_out_max
`endif
);

    import acc_pkg::*;

    acc_state_e         r_state;
    acc_state_e         w_state_nx;
    logic               r_rdy_en;
    logic [NACC-1:0]    r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    logic [ACC_W_MAX:0] w_sat;
    logic [NACC-1:0]    w_sum_sat;
    logic               w_clamp;
    logic               w_sat_unused;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_handshake;

    // rdy_en keeps the input stalled for the first cycle after reset release
    assign w_in_ready  = r_rdy_en & (r_state == ST_ACC);
    assign w_accept    = i_in_valid & w_in_ready;
    assign w_last      = (r_count == CNT_W'(NFRAME - 1));
    assign w_handshake = o_out_valid & i_out_ready;
    assign o_in_ready  = w_in_ready;

    assign w_sat        = sat_add(ACC_W_MAX'(r_acc), ACC_W_MAX'(i_in_data), NACC);
    assign w_sum_sat    = w_sat[NACC-1:0];
    assign w_clamp      = w_sat[ACC_W_MAX];
    // upper bits are zero by construction of the clamp
    assign w_sat_unused = ^w_sat[ACC_W_MAX-1:NACC];

`ifdef ACC_MINMAX_EN
    logic [NX-1:0] r_min_trk;
    logic [NX-1:0] r_max_trk;
    logic [NX-1:0] w_min_nx;
    logic [NX-1:0] w_max_nx;

    // Candidate min/max including the sample currently on the input
    always_comb begin
        w_min_nx = r_min_trk;
        w_max_nx = r_max_trk;
        if (i_in_data < r_min_trk) begin
            w_min_nx = i_in_data;
        end else begin
            w_min_nx = r_min_trk;
        end
        if (i_in_data > r_max_trk) begin
            w_max_nx = i_in_data;
        end else begin
            w_max_nx = r_max_trk;
        end
    end
`endif

    // Next-state logic; clear always returns to accumulating
    always_comb begin
        w_state_nx = r_state;
        if (i_clr) begin
            w_state_nx = ST_ACC;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept && w_last) begin
                        w_state_nx = ST_HOLD;
                    end else begin
                        w_state_nx = ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (w_handshake) begin
                        w_state_nx = ST_ACC;
                    end else begin
                        w_state_nx = ST_HOLD;
                    end
                end
                default: w_state_nx = ST_ACC;
            endcase
        end
    end

    // State, accumulator, counter and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_ACC;
            r_rdy_en    <= 1'b0;
            r_acc       <= {NACC{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_ovf       <= 1'b0;
            o_out_sum   <= {NACC{1'b0}};
            o_out_ovf   <= 1'b0;
            o_out_valid <= 1'b0;
`ifdef ACC_MINMAX_EN
            r_min_trk   <= {NX{1'b1}};
            r_max_trk   <= {NX{1'b0}};
            o_out_min   <= {NX{1'b0}};
            o_out_max   <= {NX{1'b0}};
`endif
        end else begin
            r_rdy_en <= 1'b1;
            r_state  <= w_state_nx;
            if (i_clr) begin
                // a sample offered in the clear cycle is dropped on purpose
                r_acc       <= {NACC{1'b0}};
                r_count     <= {CNT_W{1'b0}};
                r_ovf       <= 1'b0;
                o_out_valid <= 1'b0;
`ifdef ACC_MINMAX_EN
                r_min_trk   <= {NX{1'b1}};
                r_max_trk   <= {NX{1'b0}};
                o_out_min   <= {NX{1'b0}};
                o_out_max   <= {NX{1'b0}};
`endif
            end else if (w_accept) begin
                r_acc   <= w_sum_sat;
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                r_ovf   <= r_ovf | w_clamp;
`ifdef ACC_MINMAX_EN
                r_min_trk <= w_min_nx;
                r_max_trk <= w_max_nx;
`endif
                if (w_last) begin
                    o_out_sum   <= w_sum_sat;
                    o_out_ovf   <= r_ovf | w_clamp;
                    o_out_valid <= 1'b1;
`ifdef ACC_MINMAX_EN
                    o_out_min   <= w_min_nx;
                    o_out_max   <= w_max_nx;
`endif
                end
            end else if (w_handshake) begin
                // result consumed: start a fresh frame
                o_out_valid <= 1'b0;
                r_acc       <= {NACC{1'b0}};
                r_count     <= {CNT_W{1'b0}};
                r_ovf       <= 1'b0;
`ifdef ACC_MINMAX_EN
                r_min_trk   <= {NX{1'b1}};
                r_max_trk   <= {NX{1'b0}};
`endif
            end
        end
    end

endmodule
